imem_boot_loader: RTL

Byte-stream program loader that sits directly upstream of the instruction memory of the MIPS32 single-cycle SOC. It receives a framed program image one byte at a time, assembles little-endian 32-bit instruction words, writes them sequentially into instruction memory from word address 0, and holds the CPU in reset until a complete, checksum-valid image has been written.

---
 rtl/imem_boot_loader_if.sv | 25 ++
 rtl/imem_boot_loader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// master = loader side (consumes bytes, drives imem and CPU control), slave = its environment.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed byte-stream program loader: SYNC, COUNT, COUNT x 4 data bytes (LSB first), CHK.
// Writes words to imem from address 0 and holds the CPU in reset until a valid image lands.
module imem_boot_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 8
) (
  input logic               clk,
  input logic               rst,
  imem_boot_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t            stateReg;
  logic [ADDR_W:0]   countReg;
  logic [ADDR_W:0]   wordIdxReg;
  logic [1:0]        byteIdxReg;
  logic [7:0]        chkReg;
  logic [31:0]       wordBufReg;

  logic              accept;
  logic              isSync;
  logic [31:0]       laneWord;
  logic [ADDR_W-1:0] countField;
  logic [ADDR_W:0]   countDecoded;
  logic [ADDR_W:0]   wordIdxInc;

  assign accept     = bus.rx_valid && bus.rx_ready;
  assign isSync     = (bus.rx_data == SYNC_BYTE);
  assign wordIdxInc = wordIdxReg + 1'b1;

  // A count field of zero means a full memory of 2^ADDR_W words.
  assign countField   = ADDR_W'(bus.rx_data);
  assign countDecoded = (countField == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                           : {1'b0, countField};

  // Incoming byte replaces only the lane selected by the byte index.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign laneWord[8*gi +: 8] = (byteIdxReg == 2'(gi)) ? bus.rx_data
                                                           : wordBufReg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg       <= IDLE;
      countReg       <= '0;
      wordIdxReg     <= '0;
      byteIdxReg     <= '0;
      chkReg         <= '0;
      wordBufReg     <= '0;
      bus.rx_ready   <= 1'b1;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_rst    <= 1'b1;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.imem_we  <= 1'b0;
      bus.rx_ready <= 1'b1;

      case (stateReg)
        IDLE: begin
          if (accept && isSync) begin
            stateReg   <= COUNT;
            chkReg     <= '0;
            wordIdxReg <= '0;
            byteIdxReg <= '0;
            wordBufReg <= '0;
          end
        end

        COUNT: begin
          if (accept) begin
            countReg <= countDecoded;
            chkReg   <= chkReg ^ bus.rx_data;
            stateReg <= DATA;
          end
        end

        DATA: begin
          if (accept) begin
            chkReg     <= chkReg ^ bus.rx_data;
            wordBufReg <= laneWord;
            byteIdxReg <= byteIdxReg + 2'd1;
            if (byteIdxReg == 2'd3) begin
              stateReg       <= WRITE;
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= wordIdxReg[ADDR_W-1:0];
              bus.imem_wdata <= laneWord;
              bus.rx_ready   <= 1'b0;
            end
          end
        end

        // Single stall cycle while the word strobe is on the bus.
        WRITE: begin
          wordIdxReg <= wordIdxInc;
          stateReg   <= (wordIdxInc == countReg) ? CHECK : DATA;
        end

        CHECK: begin
          if (accept) begin
            if (bus.rx_data == chkReg) begin
              stateReg    <= DONE;
              bus.done    <= 1'b1;
              bus.cpu_rst <= 1'b0;
            end else begin
              stateReg    <= ERROR;
              bus.err     <= 1'b1;
              bus.cpu_rst <= 1'b1;
            end
          end
        end

        DONE, ERROR: begin
          if (accept && isSync) begin
            stateReg    <= COUNT;
            chkReg      <= '0;
            wordIdxReg  <= '0;
            byteIdxReg  <= '0;
            wordBufReg  <= '0;
            bus.cpu_rst <= 1'b1;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
          end
        end

        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule
